read_sched_arbiter: RTL

READ_SCHED_ARBITER -- requirements
Module: read_sched_arbiter

---
 rtl/sram_ctl_pkg.sv | 19 +
 rtl/wrr_picker.sv | 77 +++++++
 rtl/read_sched_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sram_ctl_pkg.sv
// Shared constants and read-scheduler state encoding for the SRAM read path.
package sram_ctl_pkg;

  localparam int DEF_NUM_PRIO = 8;
  localparam int DEF_PRIO_W   = 3;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_WEIGHT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_SOP   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_EOP   = 3'd5
  } rd_state_e;

endpackage

// File: rtl/wrr_picker.sv
// Weighted round-robin picker: per-queue credits plus a rotating start pointer.
// The winner is combinational; credits and pointer only move on a pick strobe.
module wrr_picker
  import sram_ctl_pkg::*;
#(
  parameter int NUM_PRIO = DEF_NUM_PRIO,
  parameter int PRIO_W   = DEF_PRIO_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PRIO-1:0]          prepared,
  input  logic [NUM_PRIO*WEIGHT_W-1:0] weights,
  input  logic                         pick,
  output logic [NUM_PRIO-1:0]          winner
);

  logic [WEIGHT_W-1:0] credit [NUM_PRIO];
  logic [WEIGHT_W-1:0] eff_w  [NUM_PRIO];
  logic [NUM_PRIO-1:0] has_credit;
  logic [NUM_PRIO-1:0] eligible;
  logic [PRIO_W-1:0]   ptr;
  logic [PRIO_W-1:0]   win_idx;
  logic [PRIO_W-1:0]   cand;
  logic [PRIO_W:0]     cand_sum;
  logic                reload;
  logic                found;

  // A zero weight still earns one grant per round so no queue starves.
  always_comb begin
    for (int i = 0; i < NUM_PRIO; i++) begin
      eff_w[i] = (weights[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                 WEIGHT_W'(1) : weights[i*WEIGHT_W +: WEIGHT_W];
      has_credit[i] = (credit[i] != '0);
    end
  end

  // Reloaded credits are all non-zero, so after a reload every prepared queue is eligible.
  always_comb begin
    reload   = ((prepared & has_credit) == '0);
    eligible = reload ? prepared : (prepared & has_credit);
    found    = 1'b0;
    win_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      cand_sum = {1'b0, ptr} + (PRIO_W+1)'(i);
      if (cand_sum >= (PRIO_W+1)'(NUM_PRIO)) begin
        cand_sum = cand_sum - (PRIO_W+1)'(NUM_PRIO);
      end
      cand = cand_sum[PRIO_W-1:0];
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    winner = found ? (NUM_PRIO'(1) << win_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < NUM_PRIO; i++) begin
        credit[i] <= eff_w[i];
      end
    end else if (pick && found) begin
      if (reload) begin
        for (int i = 0; i < NUM_PRIO; i++) begin
          credit[i] <= eff_w[i];
        end
      end
      credit[win_idx] <= (reload ? eff_w[win_idx] : credit[win_idx]) - WEIGHT_W'(1);
      ptr <= (win_idx == PRIO_W'(NUM_PRIO-1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/read_sched_arbiter.sv
// Packet read scheduler: picks a prepared queue (strict priority or WRR) and
// streams its packet out of a 1-cycle-latency SRAM with sop/vld/eop framing.
//
// state    | meaning
// IDLE     | wait for ready with at least one prepared queue
// ARB      | register the winning queue into grant
// SOP      | one-cycle start-of-packet marker
// DATA     | issue one SRAM read per cycle until addr_last
// DRAIN    | last read beat returns, no new reads
// EOP      | one-cycle end-of-packet marker, grant released
module read_sched_arbiter
  import sram_ctl_pkg::*;
#(
  parameter int NUM_PRIO = DEF_NUM_PRIO,
  parameter int PRIO_W   = DEF_PRIO_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sp0_wrr1,
  input  logic [NUM_PRIO*WEIGHT_W-1:0] weights,
  input  logic                         ready,
  input  logic [NUM_PRIO-1:0]          prepared,
  output logic [NUM_PRIO-1:0]          grant,
  output logic                         addr_req,
  input  logic [ADDR_W-1:0]            addr_in,
  input  logic                         addr_last,
  output logic                         sram_en,
  output logic [ADDR_W-1:0]            sram_addr,
  input  logic [DATA_W-1:0]            sram_rdata,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_sop,
  output logic                         rd_vld,
  output logic                         rd_eop
);

  rd_state_e           state, state_nxt;
  logic [NUM_PRIO-1:0] sp_win;
  logic [NUM_PRIO-1:0] wrr_win;
  logic                wrr_pick;
  logic                load_grant;
  logic                clr_grant;

  wrr_picker #(
    .NUM_PRIO (NUM_PRIO),
    .PRIO_W   (PRIO_W),
    .WEIGHT_W (WEIGHT_W)
  ) u_wrr (
    .clk      (clk),
    .rst      (rst),
    .prepared (prepared),
    .weights  (weights),
    .pick     (wrr_pick),
    .winner   (wrr_win)
  );

  // Highest index wins in strict-priority mode.
  always_comb begin
    sp_win = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (prepared[i]) begin
        sp_win = NUM_PRIO'(1) << i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_req   = 1'b0;
    sram_en    = 1'b0;
    rd_sop     = 1'b0;
    rd_eop     = 1'b0;
    wrr_pick   = 1'b0;
    load_grant = 1'b0;
    clr_grant  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ready && (|prepared)) begin
          state_nxt = ST_ARB;
        end
      end
      ST_ARB: begin
        // Requester may have vanished since IDLE; never grant an empty set.
        if (|prepared) begin
          load_grant = 1'b1;
          wrr_pick   = sp0_wrr1;
          state_nxt  = ST_SOP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SOP: begin
        rd_sop    = 1'b1;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        sram_en  = 1'b1;
        addr_req = 1'b1;
        if (addr_last) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        clr_grant = 1'b1;
        state_nxt = ST_EOP;
      end
      ST_EOP: begin
        rd_eop    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
    end else if (load_grant) begin
      grant <= sp0_wrr1 ? wrr_win : sp_win;
    end else if (clr_grant) begin
      grant <= '0;
    end
  end

  // Read data returns one cycle after the enable, so vld is the delayed enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= sram_en;
    end
  end

  assign sram_addr = sram_en ? addr_in : '0;
  assign rd_data   = rd_vld ? sram_rdata : '0;

endmodule
